u_sparse_hv_segment_packer: RTL and testbench

Downstream stage of the sparse random-HV generator. Requests a new hypervector, consumes the generator's one-hot segment stream (one LENGTH_SEGMENT-bit segment per valid pulse), encodes each segment to its set-bit index, and packs the NB_OF_SEGMENTS indices into one compact hypervector. The compact hypervector is offered downstream (item memory / encoder) over a valid/ready handshake.

---
 rtl/sparse_hv_pkg.sv | 21 ++
 rtl/u_sparse_hv_segment_packer_onehot_to_index.sv | 43 ++++
 rtl/u_sparse_hv_segment_packer.sv | 126 ++++++++++++
 tb/tb_u_sparse_hv_segment_packer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/sparse_hv_pkg.sv
// Shared defaults, packer FSM state encoding and width helper for the
// sparse random-HV segment packer.
package sparse_hv_pkg;

   localparam int HV_D              = 1024;
   localparam int HV_LENGTH_SEGMENT = 32;
   localparam int HV_NB_OF_SEGMENTS = 32;

   typedef logic [1:0] packer_state_t;

   localparam packer_state_t ST_IDLE    = 2'd0;
   localparam packer_state_t ST_REQUEST = 2'd1;
   localparam packer_state_t ST_COLLECT = 2'd2;
   localparam packer_state_t ST_HOLD    = 2'd3;

   // Index/counter width, never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/u_sparse_hv_segment_packer_onehot_to_index.sv
// Combinational segment -> set-bit index encoder.
// SPARSE_ONEHOT_CHECK_EN: lowest-set-bit encoder plus popcount != 1 error.
module onehot_to_index
   import sparse_hv_pkg::*;
#(
   parameter int LENGTH_SEGMENT = HV_LENGTH_SEGMENT,
   localparam int IDX_W = idx_width(LENGTH_SEGMENT)
) (
   input  logic [LENGTH_SEGMENT-1:0] in_segment,
`ifdef SPARSE_ONEHOT_CHECK_EN
   output logic                      out_error,
`endif
   output logic [IDX_W-1:0]          out_idx
);

`ifdef SPARSE_ONEHOT_CHECK_EN
   logic any_set;
   logic multi_set;

   // Scan from the top so the lowest set bit wins.
   always_comb begin
      out_idx   = '0;
      any_set   = 1'b0;
      multi_set = 1'b0;
      for (int i = LENGTH_SEGMENT - 1; i >= 0; i--) begin
         if (in_segment[i]) begin
            out_idx   = IDX_W'(i);
            multi_set = multi_set | any_set;
            any_set   = 1'b1;
         end
      end
      out_error = ~any_set | multi_set;
   end
`else
   always_comb begin
      out_idx = '0;
      for (int i = 0; i < LENGTH_SEGMENT; i++) begin
         if (in_segment[i]) out_idx = out_idx | IDX_W'(i);
      end
   end
`endif

endmodule

// File: rtl/u_sparse_hv_segment_packer.sv
// Packs a one-hot segment stream into a compact index hypervector.
// Optional SPARSE_ONEHOT_CHECK_EN adds sticky malformed-segment detection.
module u_sparse_hv_segment_packer
   import sparse_hv_pkg::*;
#(
   parameter int D              = HV_D,
   parameter int LENGTH_SEGMENT = HV_LENGTH_SEGMENT,
   parameter int NB_OF_SEGMENTS = HV_NB_OF_SEGMENTS,
   localparam int IDX_W = idx_width(LENGTH_SEGMENT),
   localparam int CNT_W = idx_width(NB_OF_SEGMENTS),
   localparam int HV_W  = NB_OF_SEGMENTS * IDX_W
) (
   input  logic                      clk,
   input  logic                      rst_in,
   input  logic                      in_enable,
   output logic                      start_new_hv_out,
   input  logic [LENGTH_SEGMENT-1:0] in_segment,
   input  logic                      in_sgmnt_valid,
   output logic [HV_W-1:0]           out_hv_idx,
   output logic                      out_hv_valid,
   input  logic                      in_hv_ready,
   output logic                      out_busy,
   output logic                      out_drop,
   output logic                      out_error
);

   if (D != LENGTH_SEGMENT * NB_OF_SEGMENTS) begin : g_bad_cfg
      $error("D must equal LENGTH_SEGMENT*NB_OF_SEGMENTS");
   end

   packer_state_t    state_q, state_d;
   logic [CNT_W-1:0] seg_cnt_q, seg_cnt_d;
   logic [HV_W-1:0]  idx_q, idx_d;
   logic             drop_q, drop_d;
   logic [IDX_W-1:0] enc_idx;
   logic             take_seg;

   assign take_seg = (state_q == ST_COLLECT) && in_sgmnt_valid;

`ifdef SPARSE_ONEHOT_CHECK_EN
   logic seg_err;
   logic err_q, err_d;

   onehot_to_index #(.LENGTH_SEGMENT(LENGTH_SEGMENT)) u_enc (
      .in_segment (in_segment),
      .out_error  (seg_err),
      .out_idx    (enc_idx)
   );

   always_comb begin
      err_d = err_q;
      if (state_q == ST_REQUEST) err_d = 1'b0;
      else if (take_seg)         err_d = err_q | seg_err;
   end

   always_ff @(posedge clk) begin
      if (rst_in) err_q <= 1'b0;
      else        err_q <= err_d;
   end

   assign out_error = err_q;
`else
   onehot_to_index #(.LENGTH_SEGMENT(LENGTH_SEGMENT)) u_enc (
      .in_segment (in_segment),
      .out_idx    (enc_idx)
   );

   assign out_error = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      seg_cnt_d = seg_cnt_q;
      idx_d     = idx_q;
      drop_d    = in_sgmnt_valid && (state_q != ST_COLLECT);
      case (state_q)
         ST_IDLE: begin
            if (in_enable) state_d = ST_REQUEST;
         end
         ST_REQUEST: begin
            seg_cnt_d = '0;
            idx_d     = '0;
            state_d   = ST_COLLECT;
         end
         ST_COLLECT: begin
            if (in_sgmnt_valid) begin
               for (int k = 0; k < NB_OF_SEGMENTS; k++) begin
                  if (CNT_W'(k) == seg_cnt_q) idx_d[k*IDX_W +: IDX_W] = enc_idx;
               end
               // Last slot: park the counter at 0 rather than letting it wrap.
               if (seg_cnt_q == CNT_W'(NB_OF_SEGMENTS - 1)) begin
                  seg_cnt_d = '0;
                  state_d   = ST_HOLD;
               end else begin
                  seg_cnt_d = seg_cnt_q + 1'b1;
               end
            end
         end
         ST_HOLD: begin
            if (in_hv_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_in) begin
         state_q   <= ST_IDLE;
         seg_cnt_q <= '0;
         idx_q     <= '0;
         drop_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         seg_cnt_q <= seg_cnt_d;
         idx_q     <= idx_d;
         drop_q    <= drop_d;
      end
   end

   assign start_new_hv_out = (state_q == ST_REQUEST);
   assign out_hv_valid     = (state_q == ST_HOLD);
   assign out_busy         = (state_q != ST_IDLE);
   assign out_hv_idx       = idx_q;
   assign out_drop         = drop_q;

endmodule

// File: tb/tb_u_sparse_hv_segment_packer.sv
// Scoreboard bench for u_sparse_hv_segment_packer (default parameters).
// Expectations follow SPARSE_ONEHOT_CHECK_EN when it is defined.
module tb_u_sparse_hv_segment_packer;

   localparam int LS  = 32;
   localparam int NB  = 32;
   localparam int IW  = 5;
   localparam int HVW = NB * IW;

   logic           clk = 1'b0;
   logic           rst_in;
   logic           in_enable;
   logic           start_new_hv_out;
   logic [LS-1:0]  in_segment;
   logic           in_sgmnt_valid;
   logic [HVW-1:0] out_hv_idx;
   logic           out_hv_valid;
   logic           in_hv_ready;
   logic           out_busy;
   logic           out_drop;
   logic           out_error;

   u_sparse_hv_segment_packer dut (
      .clk              (clk),
      .rst_in           (rst_in),
      .in_enable        (in_enable),
      .start_new_hv_out (start_new_hv_out),
      .in_segment       (in_segment),
      .in_sgmnt_valid   (in_sgmnt_valid),
      .out_hv_idx       (out_hv_idx),
      .out_hv_valid     (out_hv_valid),
      .in_hv_ready      (in_hv_ready),
      .out_busy         (out_busy),
      .out_drop         (out_drop),
      .out_error        (out_error)
   );

   always #5 clk = ~clk;

   int             n_cmp  = 0;
   int             n_bad  = 0;
   int             n_drop = 0;
   logic [HVW-1:0] sb_q[$];
   logic [HVW-1:0] last_exp;
   logic [LS-1:0]  segs[NB];

   task automatic check_eq(input string tag, input logic [HVW-1:0] got,
                           input logic [HVW-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [IW-1:0] enc(input logic [LS-1:0] s);
      logic [IW-1:0] r;
      r = '0;
`ifdef SPARSE_ONEHOT_CHECK_EN
      for (int i = LS - 1; i >= 0; i--) if (s[i]) r = IW'(i);
`else
      for (int i = 0; i < LS; i++) if (s[i]) r = r | IW'(i);
`endif
      return r;
   endfunction

   always @(negedge clk) begin
      if (!rst_in && out_drop) n_drop++;
      if (!rst_in && out_hv_valid && in_hv_ready) begin
         if (sb_q.size() == 0) check_eq("sb_unexpected", sb_q.size(), 1);
         else check_eq("sb_hv", out_hv_idx, sb_q.pop_front());
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_start(input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         seen = start_new_hv_out;
      end
      check_eq(tag, seen, 1);
   endtask

   // Called at the negedge where the request pulse is visible.
   task automatic run_hv(input int n, input int gap);
      logic [HVW-1:0] e;
      e = '0;
      for (int k = 0; k < NB; k++) e[k*IW +: IW] = enc(segs[k]);
      last_exp = e;
      if (n == NB) sb_q.push_back(e);
      tick();
      for (int k = 0; k < n; k++) begin
         in_segment     = segs[k];
         in_sgmnt_valid = 1'b1;
         tick();
         in_sgmnt_valid = 1'b0;
         if (k < n - 1) repeat (gap) tick();
      end
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_start"}, start_new_hv_out, 0);
      check_eq({tag, "_idx"},   out_hv_idx, 0);
      check_eq({tag, "_valid"}, out_hv_valid, 0);
      check_eq({tag, "_busy"},  out_busy, 0);
      check_eq({tag, "_drop"},  out_drop, 0);
      check_eq({tag, "_error"}, out_error, 0);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      rst_in         = 1'b1;
      in_enable      = 1'b0;
      in_segment     = '0;
      in_sgmnt_valid = 1'b0;
      in_hv_ready    = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      check_all_zero("rst");
      rst_in = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("idle_no_req", start_new_hv_out, 0);

      // 1: bit k in segment k, ready high
      for (int k = 0; k < NB; k++) segs[k] = LS'(1) << k;
      in_enable   = 1'b1;
      in_hv_ready = 1'b1;
      wait_start("t1_start");
      check_eq("t1_busy", out_busy, 1);
      run_hv(NB, 1);
      @(negedge clk);
      check_eq("t1_valid_lat", out_hv_valid, 1);
      check_eq("t1_idx", out_hv_idx, last_exp);
      @(negedge clk);
      check_eq("t1_valid_pulse", out_hv_valid, 0);
      check_eq("t1_no_early_req", start_new_hv_out, 0);
      @(negedge clk);
      check_eq("t1_restart", start_new_hv_out, 1);

      // 2: hold with ready low, drops while holding
      for (int k = 0; k < NB; k++) segs[k] = LS'(1) << $urandom_range(0, LS - 1);
      in_hv_ready = 1'b0;
      run_hv(NB, 1);
      @(negedge clk);
      d0 = n_drop;
      for (int c = 0; c < 10; c++) begin
         check_eq("t2_hold_valid", out_hv_valid, 1);
         check_eq("t2_hold_idx", out_hv_idx, last_exp);
         check_eq("t2_hold_noreq", start_new_hv_out, 0);
         if (c % 3 == 0 && c < 9) begin
            in_segment     = '1;
            in_sgmnt_valid = 1'b1;
         end
         tick();
         in_sgmnt_valid = 1'b0;
         @(negedge clk);
      end
      check_eq("t2_drops", n_drop - d0, 3);
      check_eq("t2_idx_after", out_hv_idx, last_exp);
      tick();
      in_hv_ready = 1'b1;
      wait_start("t2_restart");

      // 3: back-to-back valids, all top bit
      for (int k = 0; k < NB; k++) segs[k] = 32'h8000_0000;
      run_hv(NB, 0);
      @(negedge clk);
      check_eq("t3_valid_lat", out_hv_valid, 1);
      check_eq("t3_idx", out_hv_idx, {NB{5'd31}});
      wait_start("t3_restart");

      // 4: reset mid-collect, then restart from slot 0
      for (int k = 0; k < NB; k++) segs[k] = LS'(1) << $urandom_range(0, LS - 1);
      run_hv(10, 1);
      check_eq("t4_busy", out_busy, 1);
      rst_in = 1'b1;
      tick();
      @(negedge clk);
      check_all_zero("t4_rst");
      rst_in = 1'b0;
      wait_start("t4_start");
      for (int k = 0; k < NB; k++) segs[k] = LS'(1) << (LS - 1 - k);
      run_hv(NB, 1);
      @(negedge clk);
      check_eq("t4_valid", out_hv_valid, 1);
      check_eq("t4_slot0", out_hv_idx[0 +: IW], 31);
      wait_start("t5_start");

      // 5: malformed segments
      for (int k = 0; k < NB; k++) segs[k] = LS'(1) << k;
      segs[5] = 32'h0000_0006;
      segs[0] = 32'h0000_0000;
      run_hv(NB, 1);
      @(negedge clk);
      check_eq("t5_valid", out_hv_valid, 1);
      check_eq("t5_slot0", out_hv_idx[0 +: IW], 0);
`ifdef SPARSE_ONEHOT_CHECK_EN
      check_eq("t5_slot5", out_hv_idx[5*IW +: IW], 1);
      check_eq("t5_error", out_error, 1);
`else
      check_eq("t5_slot5", out_hv_idx[5*IW +: IW], 3);
      check_eq("t5_error", out_error, 0);
`endif
      wait_start("t6_start");
      @(negedge clk);
      check_eq("t5_err_clear", out_error, 0);
      in_enable = 1'b0;
      rst_in    = 1'b1;
      repeat (2) tick();
      check_eq("sb_drained", sb_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
